// File: rtl/alu_issue.sv
// alu_issue: RV32I ALU-class decoder with a one-entry output register plus skid register.
// Outputs are fully registered; in_ready depends only on the skid flag.
module alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_value,
    input  logic [31:0] rs2_value,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_source,
    output logic [31:0] out_arg_1,
    output logic [2:0]  out_alu_op,
    output logic        out_is_alt,
    output logic [4:0]  out_rd,
    output logic        out_write_en,
    output logic        out_illegal
);
    typedef struct packed {
        logic        illegal;
        logic        write_en;
        logic [4:0]  rd;
        logic [2:0]  alu_op;
        logic        is_alt;
        logic [31:0] source;
        logic [31:0] arg_1;
    } entry_t;

    entry_t      dec, out_q, out_d, skid_q, skid_d;
    logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic        legal, alt, is_shift;
    logic [31:0] src, arg;
    logic [2:0]  op;
    logic        in_xfer, out_xfer;

    wire [6:0] opcode = instruction[6:0];
    wire [2:0] funct3 = instruction[14:12];
    wire [6:0] funct7 = instruction[31:25];
    wire [4:0] rd     = instruction[11:7];

    always_comb begin
        legal    = 1'b0;
        alt      = 1'b0;
        src      = rs1_value;
        arg      = rs2_value;
        op       = funct3;
        is_shift = funct3 == 3'd1 || funct3 == 3'd5;
        if (opcode == 7'h33) begin
            alt   = funct7 == 7'h20;
            legal = funct7 == 7'h00 || (alt && (funct3 == 3'd0 || funct3 == 3'd5));
            arg   = is_shift ? {27'b0, rs2_value[4:0]} : rs2_value;
        end else if (opcode == 7'h13) begin
            alt   = funct3 == 3'd5 && funct7 == 7'h20;
            legal = funct3 == 3'd1 ? funct7 == 7'h00 :
                    funct3 == 3'd5 ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;
            arg   = is_shift ? {27'b0, instruction[24:20]} : {{20{instruction[31]}}, instruction[31:20]};
        end else if (opcode == 7'h37 || opcode == 7'h17) begin
            legal = 1'b1;
            src   = opcode == 7'h17 ? pc : 32'b0;
            arg   = {instruction[31:12], 12'b0};
            op    = 3'd0;
        end
        dec          = '0;
        dec.illegal  = !legal;
        dec.write_en = legal && rd != 5'd0;
        dec.rd       = legal ? rd : 5'd0;
        dec.alu_op   = legal ? op : 3'd0;
        dec.is_alt   = legal && alt;
        dec.source   = legal ? src : 32'b0;
        dec.arg_1    = legal ? arg : 32'b0;
    end

    assign in_ready = !skid_valid_q;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    // An accepted entry can only land in skid when the output register is stalled.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_xfer) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || out_xfer) begin
            out_valid_d = in_xfer;
            if (in_xfer) out_d = dec;
        end else if (in_xfer) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_source   = out_q.source;
    assign out_arg_1    = out_q.arg_1;
    assign out_alu_op   = out_q.alu_op;
    assign out_is_alt   = out_q.is_alt;
    assign out_rd       = out_q.rd;
    assign out_write_en = out_q.write_en;
    assign out_illegal  = out_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a behavioural decode model.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] instruction = '0, pc = '0, rs1_value = '0, rs2_value = '0;
    logic        in_ready, out_valid, out_is_alt, out_write_en, out_illegal;
    logic [31:0] out_source, out_arg_1;
    logic [2:0]  out_alu_op;
    logic [4:0]  out_rd;

    int checks = 0;
    int failures = 0;
    logic [74:0] q[$];
    logic        held_v = 1'b0;
    logic [74:0] held_data;

    alu_issue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_source(out_source), .out_arg_1(out_arg_1), .out_alu_op(out_alu_op),
        .out_is_alt(out_is_alt), .out_rd(out_rd), .out_write_en(out_write_en),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    wire [74:0] act = {out_illegal, out_write_en, out_rd, out_alu_op, out_is_alt, out_source, out_arg_1};

    task automatic check(input string name, input logic [74:0] a, input logic [74:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, a, e);
        end
    endtask

    // Expected response vector {illegal, write_en, rd, alu_op, is_alt, source, arg_1}.
    function automatic logic [74:0] model(input logic [31:0] ins, input logic [31:0] p,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [6:0]  opc = ins[6:0];
        logic [6:0]  f7 = ins[31:25];
        logic [2:0]  f3 = ins[14:12];
        logic        ok = 1'b0;
        logic        alt = 1'b0;
        logic [31:0] s = 32'd0;
        logic [31:0] x = 32'd0;
        logic [2:0]  aop = f3;
        if (opc == 7'h33) begin
            s = a;
            alt = f7 == 7'h20;
            ok = f7 == 7'h00 || (alt && (f3 == 3'd0 || f3 == 3'd5));
            x = (f3 == 3'd1 || f3 == 3'd5) ? (b & 32'd31) : b;
        end else if (opc == 7'h13) begin
            s = a;
            if (f3 == 3'd1) begin
                ok = f7 == 7'h00;
                x = 32'(ins[24:20]);
            end else if (f3 == 3'd5) begin
                ok = f7 == 7'h00 || f7 == 7'h20;
                alt = f7 == 7'h20;
                x = 32'(ins[24:20]);
            end else begin
                ok = 1'b1;
                x = 32'($signed(ins[31:20]));
            end
        end else if (opc == 7'h37 || opc == 7'h17) begin
            ok = 1'b1;
            s = (opc == 7'h17) ? p : 32'd0;
            x = ins & 32'hFFFF_F000;
            aop = 3'd0;
        end
        if (!ok) return {1'b1, 74'd0};
        return {1'b0, ins[11:7] != 5'd0, ins[11:7], aop, alt, s, x};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        w[6:0] = k < 3 ? 7'h33 : k < 6 ? 7'h13 : k == 6 ? 7'h37 : k == 7 ? 7'h17 : 7'($urandom);
        k = $urandom_range(0, 3);
        if (k < 2) w[31:25] = k == 0 ? 7'h00 : 7'h20;
        return w;
    endfunction

    // Monitor: evaluates the handshakes that will occur at the coming rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) check("stall_stable", act, held_data);
            held_v = out_valid && !out_ready && !flush;
            held_data = act;
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_output", {74'd0, out_valid}, 75'd0);
                else check("scoreboard", act, q.pop_front());
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(instruction, pc, rs1_value, rs2_value));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
        logic acc = 1'b0;
        in_valid = 1'b1;
        instruction = ins;
        pc = p;
        rs1_value = a;
        rs2_value = b;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready && !flush;
            step();
        end
        if (!acc) check("send_timeout", 75'd0, 75'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        logic acc;
        acc = 1'b0;
        #3;
        check("reset_flags", {73'd0, out_valid, in_ready}, 75'b01);
        check("reset_data", act, 75'd0);
        @(posedge clk);
        step();
        reset = 1'b1;
        out_ready = 1'b1;

        send(32'hFFF3_0293, 32'h0, 32'h10, 32'h0);
        check("addi_valid", {74'd0, out_valid}, 75'd1);
        check("addi", act, {1'b0, 1'b1, 5'd5, 3'd0, 1'b0, 32'h10, 32'hFFFF_FFFF});
        send(32'h4031_50B3, 32'h0, 32'h8000_0000, 32'h25);
        check("sra", act, {1'b0, 1'b1, 5'd1, 3'd5, 1'b1, 32'h8000_0000, 32'h5});
        send(32'h4031_70B3, 32'h0, 32'h1234, 32'h5678);
        check("illegal_op", act, {1'b1, 74'd0});
        send(32'h0000_0013, 32'h0, 32'h77, 32'h0);
        check("addi_x0", act, {1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 32'h77, 32'h0});
        step();
        step();

        out_ready = 1'b0;
        in_valid = 1'b1;
        instruction = 32'h1111_10B7;
        step();
        check("a_accepted_ready", {74'd0, in_ready}, 75'd1);
        instruction = 32'h2222_2137;
        step();
        check("ready_low_after_b", {74'd0, in_ready}, 75'd0);
        instruction = 32'h3333_31B7;
        step();
        check("c_held", {73'd0, in_ready, out_valid}, 75'b01);
        out_ready = 1'b1;
        step();
        check("deliver_b", {74'd0, out_valid}, 75'd1);
        step();
        in_valid = 1'b0;
        check("deliver_c", {74'd0, out_valid}, 75'd1);
        step();
        check("abc_drained", {74'd0, out_valid}, 75'd0);

        out_ready = 1'b0;
        send(32'h0010_0093, 32'h0, 32'h1, 32'h0);
        send(32'h0020_0113, 32'h0, 32'h2, 32'h0);
        check("two_held", {73'd0, in_ready, out_valid}, 75'b01);
        in_valid = 1'b1;
        instruction = 32'h0030_0193;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_state", {73'd0, in_ready, out_valid}, 75'b10);
        out_ready = 1'b1;
        step();
        step();
        check("flush_no_delivery", {74'd0, out_valid}, 75'd0);

        out_ready = 1'b0;
        send(32'h0050_0293, 32'h0, 32'h5, 32'h0);
        send(32'h0060_0313, 32'h0, 32'h6, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_flags", {73'd0, in_ready, out_valid}, 75'b10);
        check("async_reset_data", act, 75'd0);
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        send(32'h1234_53B7, 32'h4000, 32'hDEAD, 32'hBEEF);
        check("lui_after_reset_valid", {74'd0, out_valid}, 75'd1);
        check("lui_after_reset", act, {1'b0, 1'b1, 5'd7, 3'd0, 1'b0, 32'h0, 32'h1234_5000});
        send(32'h0000_1097, 32'h8000_0010, 32'h0, 32'h0);
        check("auipc", act, {1'b0, 1'b1, 5'd1, 3'd0, 1'b0, 32'h8000_0010, 32'h0000_1000});

        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || acc) begin
                in_valid = $urandom_range(0, 3) != 0;
                instruction = rand_ins();
                pc = $urandom;
                rs1_value = $urandom;
                rs2_value = $urandom;
            end
            out_ready = $urandom_range(0, 9) < 7;
            flush = $urandom_range(0, 39) == 0;
            acc = in_valid && in_ready && !flush;
            step();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        #1;
        check("drain_empty", 75'(q.size()), 75'd0);
        check("drain_valid", {74'd0, out_valid}, 75'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  upstream offers instruction plus operands.
REQ-004 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-005 SHALL have port instruction  input  32  RV32I instruction word.
REQ-006 SHALL have port pc  input  32  address of instruction (AUIPC).
REQ-007 SHALL have ports rs1_value, rs2_value  input  32 each  register-file read data.
REQ-008 SHALL have port flush  input  1  discard all held entries.
REQ-009 SHALL have port out_ready  input  1  ALU/writeback stage accepts.
REQ-010 SHALL have port out_valid  output  1  decoded entry presented.
REQ-011 SHALL have ports out_source, out_arg_1  output  32 each  ALU operands.
REQ-012 SHALL have ports out_alu_op  output  3, out_is_alt  output  1  ALU op select and alternate bit (SUB/SRA).
REQ-013 SHALL have ports out_rd  output  5, out_write_en  output  1, out_illegal  output  1.

Function
REQ-014 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-015 Storage SHALL be one output register plus one skid register; in_ready SHALL equal !skid_valid (registered, no combinational path from out_ready).
REQ-016 Latency SHALL be one cycle: entry accepted at edge N appears on outputs after edge N when output register is free or drained that cycle.
REQ-017 When output register holds unaccepted entry and a new entry is accepted, new entry SHALL go to skid; on next out transfer skid SHALL move to output register; order SHALL be preserved, no entry lost or duplicated.
REQ-018 Simultaneous in and out transfer with skid empty SHALL replace output register contents, out_valid stays 1.
REQ-019 flush SHALL clear out_valid and skid_valid at next edge and take priority over a same-cycle input transfer (flushed-cycle input discarded).
REQ-020 Decode, opcode 0x33 (OP): alu_op=funct3; source=rs1_value; arg_1=rs2_value, except funct3 1 or 5 where arg_1={27'b0, rs2_value[4:0]}.
REQ-021 OP legality: funct7=0x00 any funct3, is_alt=0; funct7=0x20 only with funct3 0 or 5, is_alt=1; all else illegal.
REQ-022 Decode, opcode 0x13 (OP-IMM): source=rs1_value; arg_1=sign-extended instruction[31:20]; alu_op=funct3; is_alt=0.
REQ-023 OP-IMM shifts: funct3 1 requires instruction[31:25]=0x00; funct3 5 requires 0x00 (SRLI) or 0x20 (SRAI, is_alt=1); arg_1={27'b0, instruction[24:20]}; other upper bits illegal.
REQ-024 Opcode 0x37 (LUI): source=0, arg_1={instruction[31:12],12'b0}, alu_op=0, is_alt=0.
REQ-025 Opcode 0x17 (AUIPC): source=pc, arg_1 as LUI, alu_op=0, is_alt=0.
REQ-026 Any other opcode SHALL be illegal.
REQ-027 Illegal entries SHALL still transfer, with out_illegal=1, out_source=0, out_arg_1=0, out_alu_op=0, out_is_alt=0, out_rd=0, out_write_en=0.
REQ-028 out_rd SHALL be instruction[11:7]; out_write_en SHALL be (rd!=0) && !illegal.
REQ-029 Outputs SHALL be stable while out_valid && !out_ready.

Reset
REQ-030 While reset=0: out_valid=0, skid_valid=0, in_ready=1, all data outputs 0, asynchronously.
REQ-031 Reset asserted mid-stall SHALL discard both held entries; first edge after release SHALL accept new input.

Verification
REQ-032 ADDI x5,x6,-1 (0xFFF30293), rs1_value=0x10, out_ready=1 -> next cycle out_valid=1, source=0x10, arg_1=0xFFFFFFFF, alu_op=0, is_alt=0, rd=5, write_en=1.
REQ-033 SRA x1,x2,x3 (0x403150B3), rs1_value=0x80000000, rs2_value=0x25 -> arg_1=0x5, alu_op=5, is_alt=1, rd=1.
REQ-034 OP funct7=0x20 funct3=7 (0x4031_70B3) -> out_illegal=1, write_en=0, all data 0; ADDI x0,x0,0 (0x00000013) -> legal, write_en=0.
REQ-035 out_ready=0, three back-to-back in_valid offers A,B,C -> A,B accepted, in_ready=0 after B, C held upstream; out_ready=1 -> A,B,C delivered in order, one per cycle.
REQ-036 Two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry not delivered.
REQ-037 Reset pulsed with two entries held -> out_valid=0, in_ready=1 immediately; LUI x7,0x12345 (0x123453B7) afterwards -> arg_1=0x12345000, source=0.
